// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core pipeline.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam int unsigned EXC_W        = 5;

  typedef enum logic [EXC_W-1:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4
  } exc_code_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Architectural PC register: redirect beats stall, stall beats next_pc.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_req,
  input  logic [31:0] redir_pc,
  input  logic        stall,
  input  logic [31:0] next_pc,
  output logic [31:0] pc
);

  // PC register with redirect/stall priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pc <= RESET_PC;
    else if (redir_req) pc <= redir_pc;
    else if (!stall)    pc <= next_pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction fetch and IF/ID pipeline register.
// Optional feature macro: FETCH_EXC_EN (address-error detection on fetch).
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      next_PC,
  input  logic             ds_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             redir_req,
  input  logic [31:0]      redir_pc,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      PC_F,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instr_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      PC8_D,
  output logic             bd_D,
  output logic             valid_D,
  output logic [EXC_W-1:0] exc_D,
  output logic [31:0]      fetch_cnt
);

`ifdef FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  // Upper bound widened to 33 bits so a range ending at 2^32 does not wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_f;
  logic        in_range;
  logic        fetch_bad;
  exc_code_e   fetch_exc;
  logic [31:0] load_word;
  logic        load;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .redir_req(redir_req),
    .redir_pc (redir_pc),
    .stall    (stall),
    .next_pc  (next_PC),
    .pc       (pc_f)
  );

  assign PC_F      = pc_f;
  assign imem_addr = pc_f;
  assign load      = !redir_req && !flush && !stall;

  // Fetch address check; a faulting fetch carries a nop plus AdEL downstream
  always_comb begin
    in_range  = ({1'b0, pc_f} >= {1'b0, IM_BASE}) && ({1'b0, pc_f} < IM_LIMIT);
    fetch_bad = EXC_EN && ((pc_f[1:0] != 2'b00) || !in_range);
    fetch_exc = fetch_bad ? EXC_ADEL : EXC_NONE;
    load_word = fetch_bad ? NOP_WORD : imem_rdata;
  end

  // IF/ID register: redirect/flush insert a bubble, stall holds, else load
  always_ff @(posedge clk or posedge reset) begin
    if (reset || 1'b0) begin
      instr_D <= NOP_WORD;
      PC_D    <= RESET_PC;
      PC8_D   <= RESET_PC + 32'd8;
      bd_D    <= 1'b0;
      valid_D <= 1'b0;
      exc_D   <= EXC_NONE;
    end else if (redir_req || flush) begin
      instr_D <= NOP_WORD;
      PC_D    <= RESET_PC;
      PC8_D   <= RESET_PC + 32'd8;
      bd_D    <= 1'b0;
      valid_D <= 1'b0;
      exc_D   <= EXC_NONE;
    end else if (!stall) begin
      instr_D <= load_word;
      PC_D    <= pc_f;
      PC8_D   <= pc_f + 32'd8;
      bd_D    <= ds_in;
      valid_D <= 1'b1;
      exc_D   <= fetch_exc;
    end
  end

  // Count of valid instructions loaded into IF/ID, wrapping modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     fetch_cnt <= '0;
    else if (load) fetch_cnt <= fetch_cnt + 32'd1;
  end

endmodule
